// File: rtl/sampler_drain_ctrl.sv
// Drains the lease sampler's record buffer into a 32-bit valid/ready word stream, five words per record.
// Build option SAMPLER_DRAIN_HEADER_EN prefixes every drain burst with a {mode, n} header word.
module sampler_drain_ctrl #(
    parameter int READ_LAT    = 2,
    parameter int WALK_CYCLES = 66
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        stop_i,
    output logic [31:0] comm_o,
    output logic        sampler_en_o,
    input  logic        full_flag_i,
    input  logic [31:0] used_i,
    input  logic [31:0] ref_address_i,
    input  logic [31:0] ref_interval_i,
    input  logic [31:0] ref_target_i,
    input  logic [63:0] ref_trace_i,
    output logic [31:0] word_o,
    output logic        word_valid_o,
    input  logic        word_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] records_o
);

`ifdef SAMPLER_DRAIN_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    localparam logic MODE_MID   = 1'b0;
    localparam logic MODE_FINAL = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RUN,
        S_WRQ,
        S_WALK,
        S_ADDR,
        S_HDR,
        S_SEND,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t      state, state_nxt, burst_end;
    logic [7:0]  wcnt;
    logic [12:0] k, n, n_lat;
    logic        mode;
    logic [2:0]  widx;
    logic [31:0] hold_addr, hold_ival, hold_tgt;
    logic [63:0] hold_trace;
    logic [31:0] records;
    logic        xfer, last_word, more_recs, wait_done, walk_done, run_full;

    assign n_lat     = (|used_i[31:13]) ? 13'h1fff : used_i[12:0];
    assign xfer      = word_valid_o & word_ready_i;
    assign last_word = (widx == 3'd4);
    assign more_recs = ({1'b0, k} + 14'd1) < {1'b0, n};
    assign wait_done = (state == S_ADDR) && (wcnt == 8'(READ_LAT));
    assign walk_done = (state == S_WALK) && (wcnt == 8'(WALK_CYCLES - 1));
    assign run_full  = (state == S_RUN) && !stop_i && full_flag_i;
    assign burst_end = (mode == MODE_MID) ? S_CLEAR : S_DONE;
    assign records_o = records;

    always_ff @(posedge clock_i) begin
        if (reset_i) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        comm_o       = '0;
        word_o       = '0;
        word_valid_o = 1'b0;
        sampler_en_o = (state != S_IDLE);
        busy_o       = 1'b1;
        done_o       = 1'b0;
        case (state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy_o     = 1'b0;
                comm_o[24] = 1'b1;
                // stop outranks a simultaneous full indication
                if (stop_i)
                    state_nxt = S_WRQ;
                else if (full_flag_i)
                    state_nxt = HDR_EN ? S_HDR : ((n_lat == '0) ? S_CLEAR : S_ADDR);
            end
            S_WRQ: begin
                comm_o[22] = 1'b1;
                state_nxt  = S_WALK;
            end
            S_WALK: begin
                if (walk_done)
                    state_nxt = HDR_EN ? S_HDR : ((n_lat == '0) ? S_DONE : S_ADDR);
            end
            S_ADDR: begin
                comm_o[24]   = (mode == MODE_MID);
                comm_o[16:4] = k;
                if (wait_done) state_nxt = S_SEND;
            end
            S_HDR: begin
                comm_o[24]   = (mode == MODE_MID);
                comm_o[16:4] = k;
                word_valid_o = 1'b1;
                word_o       = {(mode == MODE_FINAL) ? 2'b10 : 2'b01, 17'b0, n};
                if (word_ready_i) state_nxt = (n == '0) ? burst_end : S_ADDR;
            end
            S_SEND: begin
                comm_o[24]   = (mode == MODE_MID);
                comm_o[16:4] = k;
                word_valid_o = 1'b1;
                case (widx)
                    3'd0:    word_o = hold_addr;
                    3'd1:    word_o = hold_ival;
                    3'd2:    word_o = hold_tgt;
                    3'd3:    word_o = hold_trace[31:0];
                    default: word_o = hold_trace[63:32];
                endcase
                if (word_ready_i && last_word) state_nxt = more_recs ? S_ADDR : burst_end;
            end
            S_CLEAR: begin
                comm_o[24] = 1'b1;
                comm_o[23] = 1'b1;
                state_nxt  = S_RUN;
            end
            S_DONE: begin
                busy_o = 1'b0;
                done_o = 1'b1;
                if (start_i) state_nxt = S_RUN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wcnt       <= '0;
            k          <= '0;
            n          <= '0;
            mode       <= MODE_MID;
            widx       <= '0;
            hold_addr  <= '0;
            hold_ival  <= '0;
            hold_tgt   <= '0;
            hold_trace <= '0;
            records    <= '0;
        end else begin
            // one counter serves both the read-latency wait and the writeout walk
            wcnt <= (state_nxt != state) ? 8'd0 : wcnt + 8'd1;
            if (run_full || walk_done) begin
                n    <= n_lat;
                k    <= '0;
                mode <= walk_done ? MODE_FINAL : MODE_MID;
            end
            if (wait_done) begin
                hold_addr  <= ref_address_i;
                hold_ival  <= ref_interval_i;
                hold_tgt   <= ref_target_i;
                hold_trace <= ref_trace_i;
                widx       <= '0;
            end
            if (state == S_SEND && xfer) begin
                if (last_word) begin
                    widx    <= '0;
                    k       <= k + 13'd1;
                    records <= records + 32'd1;
                end else begin
                    widx <= widx + 3'd1;
                end
            end
            if (start_i && (state == S_IDLE || state == S_DONE))
                records <= '0;
        end
    end

endmodule

// File: tb/tb_sampler_drain_ctrl.sv
// Randomized bench for sampler_drain_ctrl: sampler memory model with read latency, word scoreboard, timing checks.
`timescale 1ns/1ps
module tb_sampler_drain_ctrl;
    localparam int READ_LAT    = 2;
    localparam int WALK_CYCLES = 66;
`ifdef SAMPLER_DRAIN_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic        clock_i = 1'b0;
    logic        reset_i, start_i, stop_i, full_flag_i, word_ready_i;
    logic [31:0] used_i;
    logic [31:0] comm_o, word_o, records_o;
    logic        sampler_en_o, word_valid_o, busy_o, done_o;
    logic [31:0] ref_address_i, ref_interval_i, ref_target_i;
    logic [63:0] ref_trace_i;

    sampler_drain_ctrl #(.READ_LAT(READ_LAT), .WALK_CYCLES(WALK_CYCLES)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .stop_i(stop_i),
        .comm_o(comm_o), .sampler_en_o(sampler_en_o), .full_flag_i(full_flag_i),
        .used_i(used_i), .ref_address_i(ref_address_i), .ref_interval_i(ref_interval_i),
        .ref_target_i(ref_target_i), .ref_trace_i(ref_trace_i), .word_o(word_o),
        .word_valid_o(word_valid_o), .word_ready_i(word_ready_i), .busy_o(busy_o),
        .done_o(done_o), .records_o(records_o)
    );

    always #5 clock_i = ~clock_i;

    // sampler model: record fields follow the address with READ_LAT cycles of delay
    logic [31:0] mem [0:15][0:4];
    logic [12:0] a_d1 = '0, a_d2 = '0;
    always @(posedge clock_i) begin
        a_d1 <= comm_o[16:4];
        a_d2 <= a_d1;
    end
    assign ref_address_i  = mem[a_d2[3:0]][0];
    assign ref_interval_i = mem[a_d2[3:0]][1];
    assign ref_target_i   = mem[a_d2[3:0]][2];
    assign ref_trace_i    = {mem[a_d2[3:0]][4], mem[a_d2[3:0]][3]};

    int n_checks = 0, n_pass = 0;
    int clr_cnt = 0, wrq_cnt = 0, acc_cnt = 0;
    int exp_records = 0;
    int rdy_mode = 0;
    logic [31:0] exp_q[$];
    logic [12:0] slot_q[$];
    logic        exp_mid = 1'b1;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_word = '0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        word_ready_i = 1'b1;
        forever begin
            @(posedge clock_i); #1;
            case (rdy_mode)
                0:       word_ready_i = 1'b1;
                1:       word_ready_i = ~word_ready_i;
                default: word_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clock_i) begin
        if (reset_i) begin
            prev_stall = 1'b0;
        end else begin
            if (comm_o[23]) clr_cnt++;
            if (comm_o[22]) wrq_cnt++;
            if (prev_stall)
                check_val("stall_hold", {31'b0, word_valid_o, word_o}, {31'b0, 1'b1, prev_word});
            if (word_valid_o && word_ready_i) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    check_val("extra_word", 64'(exp_q.size()), 64'd1);
                end else begin
                    check_val("word", word_o, exp_q.pop_front());
                    check_val("word_slot", comm_o[16:4], slot_q.pop_front());
                    check_val("word_enable", comm_o[24], exp_mid);
                end
            end
            prev_stall = word_valid_o && !word_ready_i;
            prev_word  = word_o;
        end
    end

    task automatic fill_mem(input int n, input logic mid);
        exp_mid = mid;
        for (int s = 0; s < 16; s++)
            for (int j = 0; j < 5; j++) mem[s][j] = $urandom;
        if (HDR != 0) begin
            exp_q.push_back({mid ? 2'b01 : 2'b10, 17'b0, 13'(n)});
            slot_q.push_back(13'd0);
        end
        for (int s = 0; s < n; s++)
            for (int j = 0; j < 5; j++) begin
                exp_q.push_back(mem[s][j]);
                slot_q.push_back(13'(s));
            end
    endtask

    task automatic do_start();
        start_i = 1'b1;
        @(posedge clock_i); #1;
        start_i = 1'b0;
        exp_records = 0;
        check_val("start_records", records_o, 0);
        check_val("start_comm", comm_o, 32'h0100_0000);
        check_val("start_en", sampler_en_o, 1);
    endtask

    task automatic mid_drain(input int n, input int rmode);
        int lat, c0;
        rdy_mode = rmode;
        fill_mem(n, 1'b1);
        used_i = 32'(n);
        c0 = clr_cnt;
        full_flag_i = 1'b1;
        @(posedge clock_i);
        lat = 0;
        while (!comm_o[23] && lat < 3000) begin
            @(posedge clock_i); #1;
            lat++;
        end
        full_flag_i = 1'b0;
        check_val("mid_clear_seen", comm_o[23], 1);
        if (rmode == 0) check_val("mid_latency", lat, 8 * n + HDR);
        @(posedge clock_i); #1;
        exp_records += n;
        check_val("mid_records", records_o, exp_records);
        check_val("mid_queue_empty", exp_q.size(), 0);
        check_val("mid_clear_once", clr_cnt - c0, 1);
        check_val("mid_back_run", {busy_o, done_o, comm_o}, {2'b00, 32'h0100_0000});
    endtask

    task automatic final_drain(input int n, input logic with_full, input int rmode);
        int lat, w0, c0;
        rdy_mode = rmode;
        fill_mem(n, 1'b0);
        used_i = 32'(n);
        w0 = wrq_cnt;
        c0 = clr_cnt;
        stop_i = 1'b1;
        if (with_full) full_flag_i = 1'b1;
        @(posedge clock_i); #1;
        stop_i = 1'b0;
        full_flag_i = 1'b0;
        lat = 0;
        while (!done_o && lat < 3000) begin
            @(posedge clock_i); #1;
            lat++;
        end
        exp_records += n;
        check_val("final_done", done_o, 1);
        if (rmode == 0) check_val("final_latency", lat, 1 + WALK_CYCLES + 8 * n + HDR);
        check_val("final_writeout_once", wrq_cnt - w0, 1);
        check_val("final_no_clear", clr_cnt - c0, 0);
        check_val("final_records", records_o, exp_records);
        check_val("final_queue_empty", exp_q.size(), 0);
        check_val("final_outputs", {busy_o, sampler_en_o, comm_o}, {2'b01, 32'h0});
    endtask

    task automatic reset_mid_drain();
        int c, t;
        rdy_mode = 0;
        fill_mem(3, 1'b1);
        used_i = 32'd3;
        c = acc_cnt;
        full_flag_i = 1'b1;
        t = 0;
        while (acc_cnt != c + 2 && t < 200) begin
            @(posedge clock_i); #1;
            t++;
        end
        check_val("rst_third_word_up", word_valid_o, 1);
        reset_i = 1'b1;
        full_flag_i = 1'b0;
        @(posedge clock_i); #1;
        check_val("rst_comm", comm_o, 0);
        check_val("rst_valid", word_valid_o, 0);
        check_val("rst_word", word_o, 0);
        check_val("rst_flags", {busy_o, done_o, sampler_en_o}, 3'b000);
        check_val("rst_records", records_o, 0);
        reset_i = 1'b0;
        exp_q.delete();
        slot_q.delete();
        exp_records = 0;
    endtask

    initial begin
        reset_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; full_flag_i = 1'b0; used_i = '0;
        for (int s = 0; s < 16; s++)
            for (int j = 0; j < 5; j++) mem[s][j] = '0;
        repeat (3) @(posedge clock_i);
        #1;
        reset_i = 1'b0;
        check_val("reset_comm", comm_o, 0);
        check_val("reset_en", sampler_en_o, 0);
        check_val("reset_word", {word_valid_o, word_o}, 0);
        check_val("reset_flags", {busy_o, done_o}, 2'b00);
        check_val("reset_records", records_o, 0);

        stop_i = 1'b1; full_flag_i = 1'b1;
        @(posedge clock_i); #1;
        stop_i = 1'b0; full_flag_i = 1'b0;
        @(posedge clock_i); #1;
        check_val("idle_ignores", {busy_o, sampler_en_o, comm_o}, 0);

        do_start();
        mid_drain(3, 0);
        mid_drain(2, 1);
        for (int i = 0; i < 5; i++) mid_drain(int'($urandom_range(1, 6)), int'($urandom_range(0, 2)));
        final_drain(5, 1'b0, 0);
        do_start();
        final_drain(2, 1'b1, 2);
        do_start();
        final_drain(0, 1'b0, 0);
        do_start();
        reset_mid_drain();
        do_start();
        mid_drain(1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
